// File: rtl/rectangle128_key_schedule.sv
// RECTANGLE-128 key schedule: expands a 128-bit master key into 26 round keys
// (one per clock) and serves them to the core through a combinational read port.

module rectangle128_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        y = '0;
        case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            4'hF: y = 4'h2;
        endcase
    end
endmodule

module rectangle128_key_schedule #(
    parameter int unsigned NUM_RKEYS = 26,
    parameter logic [4:0]  RC_INIT   = 5'h01
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         KeyLoad,
    input  logic [127:0] Key,
    input  logic [4:0]   RAddr,
    output logic [63:0]  roundKey,
    output logic         skey_ready,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t      state, state_nxt;
    logic [31:0] row      [4];
    logic [31:0] sb_row   [4];
    logic [31:0] row_nxt  [4];
    logic [3:0]  col_in   [8];
    logic [3:0]  col_out  [8];
    logic [63:0] key_file [NUM_RKEYS];
    logic [4:0]  rc, rc_nxt;
    logic [4:0]  cnt;
    logic        last;

    assign last = (cnt == 5'(NUM_RKEYS - 1));

    // Only the low eight columns pass through the S-box.
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        assign col_in[j] = {row[3][j], row[2][j], row[1][j], row[0][j]};
        rectangle128_sbox u_sbox (.x(col_in[j]), .y(col_out[j]));
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) sb_row[i] = row[i];
        for (int unsigned j = 0; j < 8; j++)
            for (int unsigned i = 0; i < 4; i++)
                sb_row[i][j] = col_out[j][i];
        row_nxt[0] = {sb_row[0][23:0], sb_row[0][31:24]} ^ sb_row[1] ^ {27'b0, rc};
        row_nxt[1] = sb_row[2];
        row_nxt[2] = {sb_row[2][15:0], sb_row[2][31:16]} ^ sb_row[3];
        row_nxt[3] = sb_row[0];
        rc_nxt     = {rc[3:0], rc[4] ^ rc[2]};
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (KeyLoad)
            state_nxt = EXPAND;
        else if (state == EXPAND && last)
            state_nxt = READY;
        busy       = (state == EXPAND);
        skey_ready = (state == READY);
    end

    // KeyLoad has priority, so a restart on the final cycle suppresses the K25 write.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int unsigned i = 0; i < 4; i++) row[i] <= '0;
            for (int unsigned i = 0; i < NUM_RKEYS; i++) key_file[i] <= '0;
            rc  <= RC_INIT;
            cnt <= '0;
        end else if (KeyLoad) begin
            for (int unsigned i = 0; i < 4; i++) row[i] <= Key[32*i +: 32];
            rc  <= RC_INIT;
            cnt <= '0;
        end else if (state == EXPAND) begin
            key_file[cnt] <= {row[3][15:0], row[2][15:0], row[1][15:0], row[0][15:0]};
            if (!last) begin
                for (int unsigned i = 0; i < 4; i++) row[i] <= row_nxt[i];
                rc  <= rc_nxt;
                cnt <= cnt + 5'd1;
            end
        end
    end

    always_comb begin
        roundKey = '0;
        if (32'(RAddr) < NUM_RKEYS) roundKey = key_file[RAddr];
    end
endmodule
